// File: rtl/rgbw_spi_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rgbw_spi_master                                               |
// | Purpose  : SPI mode-0 master that shifts one RGBW lamp command frame out |
// |            MSB first, byte 0 first, with cs active low and sck derived   |
// |            from an internal half-period divider. All outputs registered. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rgbw_spi_master #(
  parameter int CLK_DIV = 4,  // sck half-period in clk cycles (1..255)
  parameter int N_BYTES = 7   // bytes per frame (1..15)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*N_BYTES-1:0]   frame,
  output logic                   busy,
  output logic                   done,
  output logic                   byte_sent,
  output logic                   sck,
  output logic                   mosi,
  output logic                   cs
);

  localparam int         FW        = 8 * N_BYTES;
  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
  localparam logic [3:0] BYTE_LAST = 4'(N_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    half_q, half_d;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    byte_q, byte_d;
  logic [FW-1:0] shift_q, shift_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          byte_sent_q, byte_sent_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          cs_q, cs_d;
  logic          half_end;

  assign half_end = (half_q == HALF_LAST);

  // Next-state logic; outputs are derived from the next state so they come
  // out of flops aligned with the state they describe.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = frame;
          bit_d   = 3'd0;
          byte_d  = 4'd0;
          state_d = LOW;
        end
      end
      LOW: begin
        if (half_end) state_d = HIGH;
      end
      HIGH: begin
        if (half_end) begin
          shift_d = {shift_q[FW-2:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7 && byte_q != BYTE_LAST) byte_d = byte_q + 4'd1;
          if (bit_q == 3'd7 && byte_q == BYTE_LAST) state_d = HOLD;
          else                                      state_d = LOW;
        end
      end
      HOLD: begin
        if (half_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Half-period counter restarts on every state change and rests in IDLE.
    if (state_d != state_q || state_q == IDLE) half_d = 8'd0;
    else                                       half_d = half_q + 8'd1;

    cs_d        = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    sck_d       = (state_d == HIGH);
    done_d      = (state_q == HOLD) && (state_d == IDLE);
    // Pulse lands on the final high cycle of the eighth bit of a byte.
    byte_sent_d = (state_d == HIGH) && (half_d == HALF_LAST) && (bit_d == 3'd7);

    // mosi only moves when sck goes (or stays) low: it tracks the shift MSB
    // in LOW/HIGH, freezes through HOLD and parks at 0 when idle.
    if (state_d == IDLE)      mosi_d = 1'b0;
    else if (state_d == HOLD) mosi_d = mosi_q;
    else                      mosi_d = shift_d[FW-1];
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      half_q      <= 8'd0;
      bit_q       <= 3'd0;
      byte_q      <= 4'd0;
      shift_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      byte_sent_q <= 1'b0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      cs_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      shift_q     <= shift_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      byte_sent_q <= byte_sent_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      cs_q        <= cs_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign byte_sent = byte_sent_q;
  assign sck       = sck_q;
  assign mosi      = mosi_q;
  assign cs        = cs_q;

endmodule
`default_nettype wire
